// File: rtl/load_store_unit_pkg.sv
// Shared constants and bundles for the load/store unit.
// Imported by the align helper, the top and the bench.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_ILLEGAL  = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  f3;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus handshake between the load/store unit and memory.
// BusRdata is valid in the same cycle BusReady is high.
interface load_store_unit_if;

   logic        BusValid;
   logic        BusWrite;
   logic [31:0] BusAddr;
   logic [31:0] BusWdata;
   logic [3:0]  BusStrb;
   logic        BusReady;
   logic [31:0] BusRdata;

   modport master (
      output BusValid,
      output BusWrite,
      output BusAddr,
      output BusWdata,
      output BusStrb,
      input  BusReady,
      input  BusRdata
   );

   modport slave (
      input  BusValid,
      input  BusWrite,
      input  BusAddr,
      input  BusWdata,
      input  BusStrb,
      output BusReady,
      output BusRdata
   );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering, access legality and load extension.
// Purely combinational; the top supplies request and reply sides.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_off,
   input  logic [2:0]  st_f3,
   input  logic        is_store,
   input  logic [31:0] wd,
   output logic [3:0]  strb,
   output logic [31:0] wdata,
   output logic        misaligned,
   output logic        illegal,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_f3,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [3:0]  lane_strb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        is_w;
   logic        is_h;
   logic        sx;

   // Decode size, check alignment, steer store lanes
   always_comb begin
      lane_strb  = 4'b0000;
      wdata      = wd;
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (st_f3)
         F3_B: begin
            lane_strb = 4'b0001 << st_off;
            wdata     = {4{wd[7:0]}};
         end
         F3_H: begin
            lane_strb  = 4'b0011 << {st_off[1], 1'b0};
            wdata      = {2{wd[15:0]}};
            misaligned = st_off[0];
         end
         F3_W: begin
            lane_strb  = 4'b1111;
            misaligned = |st_off;
         end
         F3_BU: begin
            illegal = is_store;
         end
         F3_HU: begin
            illegal    = is_store;
            misaligned = st_off[0];
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
      strb = is_store ? lane_strb : 4'b0000;
   end

   // Pick the addressed lane and extend it to 32 bits
   always_comb begin
      ld_byte = rdata[{ld_off, 3'b000} +: 8];
      ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
      is_w    = (ld_f3[1:0] == 2'b10);
      is_h    = (ld_f3[1:0] == 2'b01);
      sx      = ~ld_f3[2];
      ld_data = {{24{sx & ld_byte[7]}}, ld_byte};
      unique case (1'b1)
         is_w:    ld_data = rdata;
         is_h:    ld_data = {{16{sx & ld_half[15]}}, ld_half};
         default: ld_data = {{24{sx & ld_byte[7]}}, ld_byte};
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one bus transaction per load/store,
// stalling the core until the access completes or aborts.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         ALUResult,
   input  logic [31:0]         WriteData,
   input  logic [2:0]          funct3,
   input  logic                MemRead,
   input  logic                MemWrite,
   output logic [31:0]         ReadData,
   output logic                Stall,
   output logic                Fault,
   output logic [1:0]          FaultCause,
   load_store_unit_if.master   bus
);

   localparam int CW =
      (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST =
      CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   lsu_req_t      req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;
   logic [1:0]    cause_q, cause_d;

   logic [3:0]    al_strb;
   logic [31:0]   al_wdata;
   logic          al_mis;
   logic          al_ill;
   logic [31:0]   al_ld;
   logic          any_req;
   logic          both_req;

   lsu_align u_align (
      .st_off     (ALUResult[1:0]),
      .st_f3      (funct3),
      .is_store   (MemWrite),
      .wd         (WriteData),
      .strb       (al_strb),
      .wdata      (al_wdata),
      .misaligned (al_mis),
      .illegal    (al_ill),
      .ld_off     (req_q.addr[1:0]),
      .ld_f3      (req_q.f3),
      .rdata      (bus.BusRdata),
      .ld_data    (al_ld)
   );

   assign any_req  = MemRead | MemWrite;
   assign both_req = MemRead & MemWrite;

   // Next-state, request latch, timeout and fault logic
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      fault_d = 1'b0;
      cause_d = cause_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               if (both_req || al_ill) begin
                  fault_d = 1'b1;
                  cause_d = FC_ILLEGAL;
                  state_d = ST_DONE;
               end else if (al_mis) begin
                  fault_d = 1'b1;
                  cause_d = FC_MISALIGN;
                  state_d = ST_DONE;
               end else begin
                  req_d.addr  = ALUResult;
                  req_d.f3    = funct3;
                  req_d.write = MemWrite;
                  req_d.wdata = al_wdata;
                  req_d.strb  = al_strb;
                  cnt_d       = '0;
                  state_d     = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (bus.BusReady) begin
               if (!req_q.write) begin
                  rdata_d = al_ld;
               end
               state_d = ST_DONE;
            end else if (TIMEOUT != 0 &&
                         cnt_q == CNT_LAST) begin
               fault_d = 1'b1;
               cause_d = FC_TIMEOUT;
               rdata_d = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   assign ReadData   = rdata_q;
   assign Fault      = fault_q;
   assign FaultCause = cause_q;
   assign Stall      =
      ((state_q == ST_IDLE) & any_req) |
      (state_q == ST_REQ);

   assign bus.BusValid = (state_q == ST_REQ);
   assign bus.BusWrite = req_q.write;
   assign bus.BusAddr  = {req_q.addr[31:2], 2'b00};
   assign bus.BusWdata = req_q.wdata;
   assign bus.BusStrb  = req_q.strb;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random accesses,
// a behavioural reference model and a random-latency bus slave.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int TMO = 16;

   typedef struct {
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] rd;
      int          stall;
      int          valid;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [2:0]  funct3;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Fault;
   logic [1:0]  FaultCause;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .funct3     (funct3),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .Fault      (Fault),
      .FaultCause (FaultCause),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   bus_t        bus_q[$];
   logic [31:0] rd_m;
   logic [1:0]  cause_m;
   logic [31:0] sl_rdata;
   int          sl_delay;
   int          wcnt;
   bit          mon_off;
   int          srun;
   int          vrun;
   bit          prev_st;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h",
                  name, act, exp);
      end
   endtask

   function automatic logic [31:0] ld_model(
      input logic [31:0] w, input logic [1:0] off,
      input logic [2:0] f);
      logic [31:0] v;
      case (f)
         F3_B, F3_BU: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f == F3_B && v >= 128)
               v = v | 32'hFFFF_FF00;
         end
         F3_H, F3_HU: begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (f == F3_H && v >= 32768)
               v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   endtask

   task automatic access(
      input bit r, input bit w,
      input logic [31:0] a, input logic [2:0] f,
      input logic [31:0] wd, input logic [31:0] rw,
      input int dly);
      exp_t e;
      bus_t b;
      int   sz;
      int   n;
      bit   legal;
      if (r)
         legal = (f inside {3'd0, 3'd1, 3'd2,
                            3'd4, 3'd5});
      else
         legal = (f inside {3'd0, 3'd1, 3'd2});
      sz = 1 << f[1:0];
      e.fault = 1'b1;
      e.valid = 0;
      e.stall = 1;
      if ((r && w) || !legal) begin
         cause_m = FC_ILLEGAL;
      end else if ((int'(a[1:0]) % sz) != 0) begin
         cause_m = FC_MISALIGN;
      end else if (dly >= TMO) begin
         cause_m = FC_TIMEOUT;
         rd_m    = 32'h0;
         e.stall = TMO + 1;
         e.valid = TMO;
      end else begin
         e.fault = 1'b0;
         e.stall = dly + 2;
         e.valid = dly + 1;
         b.wr    = w;
         b.addr  = a & 32'hFFFF_FFFC;
         b.strb  = 4'h0;
         b.wdata = wd;
         if (w) begin
            case (f)
               F3_B: begin
                  b.strb  = 4'h1 << a[1:0];
                  b.wdata = (wd & 32'hFF) * 32'h0101_0101;
               end
               F3_H: begin
                  b.strb  = 4'h3 << a[1:0];
                  b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
               end
               default: b.strb = 4'hF;
            endcase
         end else begin
            rd_m = ld_model(rw, a[1:0], f);
         end
         bus_q.push_back(b);
      end
      e.cause = cause_m;
      e.rd    = rd_m;
      exp_q.push_back(e);
      sl_rdata  = rw;
      sl_delay  = dly;
      ALUResult = a;
      funct3    = f;
      WriteData = wd;
      MemRead   = r;
      MemWrite  = w;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (Stall && n < 60);
      if (Stall) begin
         errors++;
         checks++;
         $display("FAIL hang: Stall still %b after %0d",
                  Stall, n);
         finish_now();
      end
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      repeat (1 + $urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bus slave: ready after sl_delay REQ cycles
   initial begin
      bus.BusReady = 1'b0;
      bus.BusRdata = 32'h0;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.BusValid) begin
            bus.BusReady = (wcnt == sl_delay);
            wcnt++;
         end else begin
            bus.BusReady = 1'b0;
            wcnt = 0;
         end
         bus.BusRdata =
            bus.BusReady ? sl_rdata : $urandom;
      end
   end

   // Completion monitor: pops on the cycle Stall falls
   initial begin
      exp_t e;
      srun = 0;
      vrun = 0;
      prev_st = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_off) begin
            srun = 0;
            vrun = 0;
            prev_st = 1'b0;
         end else begin
            if (Stall) srun++;
            if (bus.BusValid) vrun++;
            if (!Stall && prev_st) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL exp_q: got empty want item");
               end else begin
                  e = exp_q.pop_front();
                  chk("Fault", 32'(Fault), 32'(e.fault));
                  chk("FaultCause", 32'(FaultCause),
                      32'(e.cause));
                  chk("ReadData", ReadData, e.rd);
                  chk("stall_cycles", srun, e.stall);
                  chk("valid_cycles", vrun, e.valid);
               end
               srun = 0;
               vrun = 0;
            end else if (Fault) begin
               chk("stray_fault", 32'(Fault), 32'h0);
            end
            prev_st = Stall;
         end
      end
   end

   // Bus monitor: checks fields at each handshake
   always @(negedge clk) begin
      bus_t b;
      if (!mon_off && bus.BusValid && bus.BusReady) begin
         if (bus_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL bus_q: got empty want item");
         end else begin
            b = bus_q.pop_front();
            chk("BusWrite", 32'(bus.BusWrite), 32'(b.wr));
            chk("BusAddr", bus.BusAddr, b.addr);
            chk("BusStrb", 32'(bus.BusStrb), 32'(b.strb));
            if (b.wr)
               chk("BusWdata", bus.BusWdata, b.wdata);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  f;
      int          k;
      int          dly;
      mon_off   = 1'b0;
      rst       = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = 32'h0;
      WriteData = 32'h0;
      funct3    = 3'b000;
      sl_rdata  = 32'h0;
      sl_delay  = 0;
      rd_m      = 32'h0;
      cause_m   = FC_NONE;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ReadData", ReadData, 32'h0);
      chk("rst Fault", 32'(Fault), 32'h0);
      chk("rst FaultCause", 32'(FaultCause), 32'h0);
      chk("rst Stall", 32'(Stall), 32'h0);
      chk("rst BusValid", 32'(bus.BusValid), 32'h0);
      chk("rst BusAddr", bus.BusAddr, 32'h0);
      chk("rst BusStrb", 32'(bus.BusStrb), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      access(1, 0, 32'h100, F3_W, 0, 32'hDEADBEEF, 0);
      access(1, 0, 32'h103, F3_B, 0, 32'h80FF_FFFF, 0);
      access(1, 0, 32'h103, F3_BU, 0, 32'h80FF_FFFF, 1);
      access(1, 0, 32'h102, F3_HU, 0, 32'h80FF_FFFF, 0);
      access(1, 0, 32'h102, F3_H, 0, 32'h80FF_1234, 2);
      access(0, 1, 32'h201, F3_B, 32'hAB, 0, 0);
      access(0, 1, 32'h202, F3_H, 32'h5566_BEEF, 0, 3);
      access(1, 0, 32'h102, F3_W, 0, 32'h1, 0);
      access(1, 1, 32'h100, F3_W, 0, 32'h1, 0);
      access(0, 1, 32'h100, F3_BU, 32'h1, 0, 0);
      access(1, 0, 32'h100, 3'b011, 0, 32'h1, 0);
      access(1, 0, 32'h104, F3_W, 0, 32'h1234, 40);
      access(1, 0, 32'h108, F3_W, 0, 32'h5678, 15);
      access(0, 1, 32'hFFFF_FFFC, F3_W,
             32'hCAFE_F00D, 0, 0);
      access(1, 0, 32'hFFFF_FFFC, F3_W, 0, 32'h7, 0);

      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         if ($urandom_range(0, 15) == 0)
            a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         f = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0)
            f = 3'($urandom_range(0, 2));
         dly = $urandom_range(0, 4);
         if ($urandom_range(0, 11) == 0)
            dly = TMO + $urandom_range(0, 8);
         k = $urandom_range(0, 19);
         if (k < 9)
            access(1, 0, a, f, $urandom, $urandom, dly);
         else if (k < 18)
            access(0, 1, a, f, $urandom, $urandom, dly);
         else
            access(1, 1, a, f, $urandom, $urandom, dly);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q drained", exp_q.size(), 0);
      chk("bus_q drained", bus_q.size(), 0);

      mon_off   = 1'b1;
      sl_delay  = 1000;
      ALUResult = 32'h300;
      funct3    = F3_W;
      MemRead   = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("pre-rst BusValid", 32'(bus.BusValid), 32'h1);
      rst     = 1'b1;
      MemRead = 1'b0;
      @(posedge clk);
      #1;
      chk("mid-rst BusValid", 32'(bus.BusValid), 32'h0);
      chk("mid-rst Stall", 32'(Stall), 32'h0);
      chk("mid-rst Fault", 32'(Fault), 32'h0);
      chk("mid-rst ReadData", ReadData, 32'h0);
      rst = 1'b0;
      rd_m    = 32'h0;
      cause_m = FC_NONE;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("post-rst FaultCause", 32'(FaultCause), 32'h0);
      mon_off = 1'b0;
      @(posedge clk);
      #1;
      access(1, 0, 32'h400, F3_HU, 0, 32'hFEDC_BA98, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("final exp_q", exp_q.size(), 0);
      chk("final bus_q", bus_q.size(), 0);
      finish_now();
   end

endmodule
